bin2bcd16: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of `sqrt32`. It takes the 16-bit root `y` and produces five packed BCD digits plus a significant-digit count for decimal display or logging. Conversion uses shift-and-add-3 (double-dabble), one bit per clock. `start` is edge-triggered internally, so `sqrt32.rdy` can drive it directly.

---
 rtl/bin2bcd16.sv | 114 +++++++++++
 tb/tb_bin2bcd16.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd16.sv
// Sequential 16-bit binary to 5-digit packed BCD converter.
// Double-dabble, one bit per clock, with registered result and digit count.
module bin2bcd16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        rdy,
  output logic [19:0] bcd,
  output logic [2:0]  ndigits
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        start_q;
  logic        go;
  logic [15:0] shreg, shreg_n;
  logic [19:0] scr, scr_n;
  logic [19:0] adj;
  logic [3:0]  cnt, cnt_n;
  logic        busy_n, rdy_n;
  logic [19:0] bcd_n;
  logic [2:0]  nd_n;

  assign go = start & ~start_q;

  function automatic logic [2:0] count_digits(
    input logic [19:0] v
  );
    logic [2:0] n;
    if (v[19:16] != 4'd0)      n = 3'd5;
    else if (v[15:12] != 4'd0) n = 3'd4;
    else if (v[11:8] != 4'd0)  n = 3'd3;
    else if (v[7:4] != 4'd0)   n = 3'd2;
    else                       n = 3'd1;
    return n;
  endfunction

  // all nibbles corrected in parallel from pre-shift values
  always_comb begin
    adj = scr;
    for (int i = 0; i < 5; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    scr_n   = scr;
    cnt_n   = cnt;
    busy_n  = busy;
    rdy_n   = rdy;
    bcd_n   = bcd;
    nd_n    = ndigits;
    unique case (state)
      IDLE, DONE: begin
        if (go) begin
          shreg_n = bin;
          scr_n   = 20'd0;
          cnt_n   = 4'd0;
          rdy_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        scr_n   = {adj[18:0], shreg[15]};
        shreg_n = {shreg[14:0], 1'b0};
        cnt_n   = cnt + 4'd1;
        if (cnt == 4'd15) begin
          bcd_n   = scr_n;
          nd_n    = count_digits(scr_n);
          rdy_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      shreg   <= 16'd0;
      scr     <= 20'd0;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      rdy     <= 1'b0;
      bcd     <= 20'd0;
      ndigits <= 3'd0;
    end else begin
      state   <= state_n;
      start_q <= start;
      shreg   <= shreg_n;
      scr     <= scr_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      rdy     <= rdy_n;
      bcd     <= bcd_n;
      ndigits <= nd_n;
    end
  end

endmodule

// File: tb/tb_bin2bcd16.sv
// Directed and sampled-sweep bench for bin2bcd16.
// Expected results come from a decimal model via a scoreboard queue.
module tb_bin2bcd16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        rdy;
  logic [19:0] bcd;
  logic [2:0]  ndigits;

  typedef struct {
    logic [19:0] bcd;
    logic [2:0]  nd;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [19:0] last_bcd = 20'd0;

  bin2bcd16 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .rdy     (rdy),
    .bcd     (bcd),
    .ndigits (ndigits)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int v);
    exp_t r;
    r.bcd = {4'(v / 10000), 4'((v / 1000) % 10),
             4'((v / 100) % 10), 4'((v / 10) % 10),
             4'(v % 10)};
    r.nd  = (v >= 10000) ? 3'd5 :
            (v >= 1000)  ? 3'd4 :
            (v >= 100)   ? 3'd3 :
            (v >= 10)    ? 3'd2 : 3'd1;
    return r;
  endfunction

  function automatic int isqrt(input int x);
    int y = 0;
    while ((y + 1) * (y + 1) <= x) y++;
    return y;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where rdy rises
  task automatic run_conv(input logic [15:0] v,
                          input string tag,
                          input bit mid);
    exp_t e;
    int   lat = 0;
    bit   got = 0;
    start = 1'b1;
    bin   = v;
    sbq.push_back(model(int'(v)));
    for (int i = 1; i <= 40 && !got; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      if (mid && i == 8) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rdy"}, 32'(rdy), 32'd0);
        chk({tag, "_hold"}, 32'(bcd), 32'(last_bcd));
      end
      if (rdy) begin
        got = 1;
        lat = i;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd17);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_bcd"}, 32'(bcd), 32'(e.bcd));
      chk({tag, "_nd"}, 32'(ndigits), 32'(e.nd));
      last_bcd = e.bcd;
    end
  endtask

  initial begin
    exp_t e;
    int   nb;
    int   lat;
    bit   pb;
    bit   got;
    int   bnd[9] = '{9, 10, 99, 100, 999,
                     1000, 9999, 10000, 65535};

    reset = 1'b0;
    start = 1'b1;
    bin   = 16'd0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_nd", 32'(ndigits), 32'd0);

    // start already high while reset releases
    reset = 1'b1;
    run_conv(16'd0, "zero", 0);

    tick();
    run_conv(16'd65535, "max", 1);
    tick();
    run_conv(16'(isqrt(65025)), "chain", 0);

    // level start held for 50 cycles
    tick();
    start = 1'b1;
    bin   = 16'd1234;
    sbq.push_back(model(1234));
    nb  = 0;
    pb  = busy;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (busy && !pb) nb++;
      pb = busy;
      if (rdy && !got) begin
        got = 1;
        lat = i;
        e   = sbq.pop_front();
        chk("level_bcd", 32'(bcd), 32'(e.bcd));
        chk("level_nd", 32'(ndigits), 32'(e.nd));
        last_bcd = e.bcd;
      end
    end
    start = 1'b0;
    chk("level_lat", 32'(lat), 32'd17);
    chk("level_busy_rises", 32'(nb), 32'd1);

    // back-to-back: second start lands on E17
    tick();
    run_conv(16'd1000, "b2b1", 0);
    run_conv(16'd9, "b2b2", 1);

    // reset in the middle of a conversion
    tick();
    start = 1'b1;
    bin   = 16'd500;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2 reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_rdy", 32'(rdy), 32'd0);
    chk("mrst_bcd", 32'(bcd), 32'd0);
    chk("mrst_nd", 32'(ndigits), 32'd0);
    tick();
    reset    = 1'b1;
    last_bcd = 20'd0;
    tick();
    run_conv(16'd4096, "after_rst", 0);

    foreach (bnd[k]) begin
      tick();
      run_conv(16'(bnd[k]), "bound", 0);
    end

    for (int v = 3; v < 65536; v += 37) begin
      tick();
      run_conv(16'(v), "sweep", 0);
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
